// File: rtl/unsigned_multiply_core.sv
// Two-stage unsigned multiplier. Operands are registered, then a carry-save
// AND-array with a final ripple-carry adder forms the registered product.
module unsigned_multiply_core #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic [2*WIDTH-1:0]   dataout
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;

  // Partial products, per-row sum vectors and per-row carry vectors.
  // Column WIDTH-1 of every row never carries, so carry vectors are one bit narrower.
  logic [WIDTH-1:0] pp  [WIDTH];
  logic [WIDTH-1:0] s   [WIDTH];
  logic [WIDTH-2:0] c   [WIDTH];
  logic [WIDTH-1:0] fc;

  assign a_d = dataa;
  assign b_d = datab;

  // Stage 1 operand capture and stage 2 product capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
    end
  end

  // Array reduction: row i adds pp row i into the shifted previous sum/carry
  always_comb begin
    pp     = '{default: '0};
    s      = '{default: '0};
    c      = '{default: '0};
    fc     = '0;
    prod_d = '0;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp[i][j] = a_q[j] & b_q[i];
      end
    end

    s[0]      = pp[0];
    c[0]      = '0;
    prod_d[0] = s[0][0];

    for (int unsigned i = 1; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH - 1; j++) begin
        s[i][j] = pp[i][j] ^ s[i-1][j+1] ^ c[i-1][j];
        c[i][j] = (pp[i][j] & s[i-1][j+1]) |
                  (pp[i][j] & c[i-1][j])   |
                  (s[i-1][j+1] & c[i-1][j]);
      end
      s[i][WIDTH-1] = pp[i][WIDTH-1];
      prod_d[i]     = s[i][0];
    end

    // Final ripple-carry adder merges the last sum and carry vectors
    fc[0] = 1'b0;
    for (int unsigned k = 0; k < WIDTH - 1; k++) begin
      prod_d[WIDTH+k] = s[WIDTH-1][k+1] ^ c[WIDTH-1][k] ^ fc[k];
      fc[k+1]         = (s[WIDTH-1][k+1] & c[WIDTH-1][k]) |
                        (s[WIDTH-1][k+1] & fc[k])         |
                        (c[WIDTH-1][k] & fc[k]);
    end
    prod_d[PW-1] = fc[WIDTH-1];
  end

  assign dataout = prod_q;

endmodule

// File: tb/tb_unsigned_multiply_core.sv
// Self-checking bench: directed and random operand pairs against a
// queue-based two-stage latency model using plain integer multiplication.
module tb_unsigned_multiply_core;

  localparam int unsigned W  = 5;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  dataa;
  logic [W-1:0]  datab;
  logic [PW-1:0] dataout;

  int checks   = 0;
  int failures = 0;
  int model_q[$];
  int exp_v;

  always #5 clk = ~clk;

  unsigned_multiply_core #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dataa   (dataa),
    .datab   (datab),
    .dataout (dataout)
  );

  task automatic check(input string tag, input int expv);
    checks++;
    assert (dataout === PW'(expv))
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dataout, expv);
    end
  endtask

  // Drive a pair, clock once, then compare against the product of the
  // pair that was registered one edge earlier.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    dataa = a;
    datab = b;
    @(posedge clk);
    exp_v = model_q.pop_front();
    model_q.push_back(int'(a) * int'(b));
    #1 check(tag, exp_v);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_q.push_back(0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    // Reset with maximum operands: output must be zero at once and while held
    rst_n = 1'b0;
    dataa = 5'd31;
    datab = 5'd31;
    model_reset();
    #2 check("reset_immediate", 0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_held", 0);
    end
    rst_n = 1'b1;

    // Zero operands
    step(5'd0, 5'd0, "zero_cap");
    step(5'd0, 5'd0, "zero");
    check("zero_const", 0);

    // Maximum operands
    step(5'd31, 5'd31, "max_cap");
    step(5'd31, 5'd31, "max");
    check("max_const", 961);

    // Back-to-back pairs
    step(5'd3,  5'd5, "pipe_a");
    step(5'd7,  5'd9, "pipe_b");
    check("pipe_15", 15);
    step(5'd31, 5'd1, "pipe_c");
    check("pipe_63", 63);
    step(5'd0,  5'd0, "pipe_d");
    check("pipe_31", 31);
    step(5'd0,  5'd0, "pipe_e");

    // Identity and zero boundaries
    step(5'd1,  5'd22, "one_a");
    step(5'd22, 5'd1,  "one_b");
    check("one_a_const", 22);
    step(5'd0,  5'd19, "zero_a");
    check("one_b_const", 22);
    step(5'd27, 5'd0,  "zero_b");
    check("zero_a_const", 0);
    step(5'd27, 5'd0,  "zero_b_hold");
    check("zero_b_const", 0);

    // Random pairs, each held for two edges
    for (int n = 0; n < 100; n++) begin
      ra = W'($urandom_range(0, 31));
      rb = W'($urandom_range(0, 31));
      step(ra, rb, "rand_first");
      step(ra, rb, "rand_hold");
      check("rand_ref", int'(ra) * int'(rb));
    end

    // Reset pulse between edges discards an in-flight 31*31
    step(5'd31, 5'd31, "midrst_cap");
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("midrst_async", 0);
    #2 rst_n = 1'b1;
    step(5'd2, 5'd3, "midrst_post0");
    check("midrst_no961", 0);
    step(5'd2, 5'd3, "midrst_post1");
    check("midrst_new", 6);
    step(5'd2, 5'd3, "midrst_post2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unsigned_multiply_core.md
UNSIGNED_MULTIPLY_CORE -- requirements
Module: unsigned_multiply_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, setting the operand width in bits; all requirements below use WIDTH=5 unless stated otherwise.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port dataa, input, WIDTH bits: unsigned multiplicand.
REQ-005 The block SHALL have port datab, input, WIDTH bits: unsigned multiplier.
REQ-006 The block SHALL have port dataout, output, 2*WIDTH bits: unsigned product dataa*datab.

Function
REQ-007 dataout SHALL equal dataa*datab as a 2*WIDTH-bit unsigned product; it SHALL never truncate, saturate or sign-extend (max 31*31=961).
REQ-008 Stage 1: on each rising clk, dataa and datab SHALL be captured into operand registers a_q and b_q.
REQ-009 Stage 2: on each rising clk, the product of a_q and b_q SHALL be captured into the output register driving dataout.
REQ-010 Latency SHALL be exactly 2 rising clk edges from an input change to the matching dataout; throughput SHALL be one new operand pair per cycle, with no stall or handshake.
REQ-011 Inputs held stable for 2 or more cycles SHALL yield a stable, correct dataout from the second rising edge onward.
REQ-012 The product SHALL be built as an explicit array multiplier:
- WIDTH x WIDTH partial-product AND matrix pp[i][j] = a_q[j] & b_q[i].
- Rows reduced by ripple rows of full/half adders.
- Final ripple-carry adder.
The "*" operator SHALL NOT be used, so the netlist maps to LUT/adder logic.
REQ-013 Product bit 0 SHALL equal a_q[0]&b_q[0]; bit 2*WIDTH-1 SHALL be the final carry-out.
REQ-014 dataout SHALL come directly from a flop; there SHALL be no combinational path from dataa/datab to dataout.
REQ-015 Boundaries:
- Either operand 0 gives 0.
- Operand 1 gives the other operand zero-extended.
- 31*31 = 961 (10'b1111000001) with no overflow.
REQ-016 There SHALL be no X-propagation: dataout SHALL be fully defined whenever the inputs were known for the 2 preceding edges.

Reset
REQ-017 While rst_n=0, a_q, b_q and dataout SHALL be 0 immediately, without waiting for a clock edge.
REQ-018 After rst_n rises, the first valid product SHALL appear 2 rising edges after the first capture.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight operands; no pre-reset product SHALL appear after release.

Verification
REQ-020 Reset: assert rst_n=0 with dataa=31, datab=31 -> dataout=0 immediately and while held.
REQ-021 Zero: dataa=0, datab=0 applied after reset, wait 2 edges -> dataout=0.
REQ-022 Max: dataa=31, datab=31, wait 2 edges -> dataout=961.
REQ-023 Pipelined: back-to-back pairs (3,5), (7,9), (31,1) on consecutive edges -> dataout 15, 63, 31 on consecutive edges starting 2 edges after the first pair.
REQ-024 Random: 100 random 5-bit pairs, each held 2 cycles, compared against a reference product -> zero mismatches; the bench reports pass or the mismatch count.
REQ-025 Mid-reset: apply (31,31), pulse rst_n low between the edges -> dataout=0 and 961 never appears afterward.
